// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, payload pass-through, CRC-32 FCS and inter-frame gap.
// Define ETH_TX_PAD_EN to pad short frames with zero bytes up to MIN_FRAME before the FCS.
module eth_tx_framer #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MIN_FRAME  = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StPreamble = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
`ifdef ETH_TX_PAD_EN
    localparam logic [2:0] StPad      = 3'd3;
    localparam logic [10:0] MinFrame  = 11'(MIN_FRAME);
`endif
    localparam logic [2:0] StFcs      = 3'd4;
    localparam logic [2:0] StIfg      = 3'd5;

    localparam logic [15:0] IfgCnt = 16'(IFG_CYCLES);

    if (MIN_FRAME > 2047 || IFG_CYCLES > 65535) begin : g_bad_param
        $error("eth_tx_framer: MIN_FRAME or IFG_CYCLES out of range");
    end

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        underrun_q, underrun_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [10:0] byte_cnt_inc;
    logic        data_phase;
    logic [31:0] fcs;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign fcs          = ~crc_q;
    // The SFD cycle (last preamble byte on the wire) already accepts the first data byte.
    assign data_phase   = (state_q == StData) || ((state_q == StPreamble) && (cnt_q == 16'd7));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        tx_en_d     = 1'b0;
        tx_data_d   = 8'h00;
        underrun_d  = underrun_q;
        frame_cnt_d = frame_cnt_q;
        s_ready     = 1'b0;

        case (state_q)
            StIdle: begin
                if (s_valid) begin
                    state_d    = StPreamble;
                    cnt_d      = 16'd0;
                    tx_en_d    = 1'b1;
                    tx_data_d  = 8'h55;
                    underrun_d = 1'b0;
                    crc_d      = 32'hFFFFFFFF;
                    byte_cnt_d = 11'd0;
                end
            end
            StPreamble: begin
                tx_en_d   = 1'b1;
                tx_data_d = (cnt_q == 16'd6) ? 8'hD5 : 8'h55;
                cnt_d     = cnt_q + 16'd1;
            end
`ifdef ETH_TX_PAD_EN
            StPad: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= MinFrame) begin
                    state_d = StFcs;
                    cnt_d   = 16'd0;
                end
            end
`endif
            StFcs: begin
                tx_en_d   = 1'b1;
                tx_data_d = fcs[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d     = cnt_q + 16'd1;
                if (cnt_q == 16'd3) begin
                    state_d     = StIfg;
                    cnt_d       = 16'd0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            StIfg: begin
                // Normal entry sees the last FCS byte for one cycle first, so it counts from 0.
                if (cnt_q >= IfgCnt) begin
                    state_d = StIdle;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 16'd0;
            end
        endcase

        if (data_phase) begin
            s_ready = 1'b1;
            if (s_valid) begin
                tx_en_d    = 1'b1;
                tx_data_d  = s_data;
                crc_d      = crc_byte(crc_q, s_data);
                byte_cnt_d = byte_cnt_inc;
                cnt_d      = 16'd0;
                if (s_last) begin
`ifdef ETH_TX_PAD_EN
                    state_d = (byte_cnt_inc < MinFrame) ? StPad : StFcs;
`else
                    state_d = StFcs;
`endif
                end else begin
                    state_d = StData;
                end
            end else begin
                // Starvation: abort, TX_EN already low in the first IFG cycle.
                tx_en_d    = 1'b0;
                tx_data_d  = 8'h00;
                underrun_d = 1'b1;
                state_d    = StIfg;
                cnt_d      = 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            byte_cnt_q  <= 11'd0;
            crc_q       <= 32'hFFFFFFFF;
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign busy      = (state_q != StIdle);
    assign underrun  = underrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: driver queues expected wire bytes and burst lengths,
// a negedge monitor pops and compares them against TX_DATA/TX_EN.
module tb_eth_tx_framer;

    localparam int MINF = 60;
`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int         len_q[$];
    logic [7:0] fd[128];
    int         last_gap = 0;
    int         exp_fc = 0;

    int  run_len = 0;
    int  low_len = 0;
    bit  in_run = 1'b0;

    eth_tx_framer #(.IFG_CYCLES(12), .MIN_FRAME(MINF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .busy      (busy),
        .underrun  (underrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bitwise reference CRC-32 over fd[0..n-1] followed by zero padding up to tot bytes.
    function automatic logic [31:0] crc_model(input int n, input int tot);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < tot; k++) begin
            b = (k < n) ? fd[k] : 8'h00;
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic fill_ramp(input int n, input logic [7:0] first);
        for (int k = 0; k < n; k++) fd[k] = first + 8'(k);
    endtask

    task automatic send_frame(input int n, input int abort_at, input bit keep,
                              input bit ovr, input logic [31:0] ovr_fcs);
        int tot;
        int i;
        int cyc;
        bit rdy;
        logic [31:0] f;
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        if (abort_at > 0) begin
            for (int k = 0; k < abort_at; k++) exp_q.push_back(fd[k]);
            len_q.push_back(8 + abort_at);
        end else begin
            tot = (PAD && n < MINF) ? MINF : n;
            for (int k = 0; k < tot; k++) exp_q.push_back((k < n) ? fd[k] : 8'h00);
            f = ovr ? ovr_fcs : crc_model(n, tot);
            for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
            len_q.push_back(8 + tot + 4);
        end
        i = 0;
        cyc = 0;
        s_valid = 1'b1;
        s_data = fd[0];
        s_last = (n == 1);
        while (i < n) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                i++;
                if (i == abort_at) begin
                    s_valid = 1'b0;
                    s_last = 1'b0;
                    s_data = 8'h00;
                    @(posedge clk);
                    #1;
                    return;
                end
                if (i < n) begin
                    s_data = fd[i];
                    s_last = (i == n - 1);
                end
            end
            if (cyc > 4 * n + 100) begin
                check("accept_timeout", 32'(i), 32'(n));
                break;
            end
        end
        s_last = 1'b0;
        if (!keep) begin
            s_valid = 1'b0;
            s_data = 8'h00;
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy || exp_q.size() != 0 || len_q.size() != 0) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                check("idle_timeout", {31'b0, busy}, 32'd0);
                exp_q.delete();
                len_q.delete();
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_run = 1'b0;
            run_len = 0;
            low_len = 0;
        end else if (tx_en) begin
            if (!in_run) begin
                last_gap = low_len;
                in_run = 1'b1;
                run_len = 0;
            end
            run_len++;
            if (exp_q.size() == 0) begin
                check("unexpected_tx_byte", {24'b0, tx_data}, 32'hFFFFFFFF);
            end else begin
                check("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            end
        end else begin
            if (in_run) begin
                in_run = 1'b0;
                if (len_q.size() == 0) check("unexpected_burst", 32'(run_len), 32'd0);
                else check("tx_en_length", 32'(run_len), 32'(len_q.pop_front()));
                low_len = 0;
            end
            low_len++;
            check("tx_data_idle_zero", {24'b0, tx_data}, 32'd0);
        end
    end

    task automatic check_reset_outputs();
        check("rst_tx_en", {31'b0, tx_en}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 60-byte ramp frame
        fill_ramp(60, 8'h00);
        send_frame(60, 0, 1'b0, 1'b0, 32'h0);
        wait_idle();
        exp_fc++;
        check("fc_after_60", {16'b0, frame_cnt}, 32'(exp_fc));
        check("underrun_after_60", {31'b0, underrun}, 32'd0);

        // "123456789": known CRC-32 0xCBF43926 when unpadded
        fill_ramp(9, 8'h31);
        send_frame(9, 0, 1'b0, !PAD, 32'hCBF43926);
        wait_idle();
        exp_fc++;
        check("fc_after_check_str", {16'b0, frame_cnt}, 32'(exp_fc));

        // 14-byte frame (padded to 60 when padding is built in)
        fill_ramp(14, 8'hA0);
        send_frame(14, 0, 1'b0, 1'b0, 32'h0);
        wait_idle();
        exp_fc++;

        // single-byte frame
        fill_ramp(1, 8'h7E);
        send_frame(1, 0, 1'b0, 1'b0, 32'h0);
        wait_idle();
        exp_fc++;
        check("fc_after_1byte", {16'b0, frame_cnt}, 32'(exp_fc));

        // back-to-back with S_VALID held
        fill_ramp(20, 8'h40);
        send_frame(20, 0, 1'b1, 1'b0, 32'h0);
        send_frame(20, 0, 1'b0, 1'b0, 32'h0);
        wait_idle();
        exp_fc += 2;
        check("b2b_gap", 32'(last_gap), 32'd13);
        check("fc_after_b2b", {16'b0, frame_cnt}, 32'(exp_fc));

        // starvation abort after 20 data bytes, then a normal frame
        fill_ramp(40, 8'hC0);
        send_frame(40, 20, 1'b0, 1'b0, 32'h0);
        check("abort_tx_en", {31'b0, tx_en}, 32'd0);
        check("abort_underrun", {31'b0, underrun}, 32'd1);
        check("abort_fc", {16'b0, frame_cnt}, 32'(exp_fc));
        fill_ramp(30, 8'h10);
        send_frame(30, 0, 1'b0, 1'b0, 32'h0);
        wait_idle();
        exp_fc++;
        check("post_abort_underrun", {31'b0, underrun}, 32'd0);
        check("post_abort_gap", 32'(last_gap), 32'd13);
        check("post_abort_fc", {16'b0, frame_cnt}, 32'(exp_fc));

        // reset while the 2nd FCS byte is on the wire
        fill_ramp(60, 8'h00);
        send_frame(60, 0, 1'b0, 1'b0, 32'h0);
        cyc = 0;
        while (exp_q.size() != 3 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        check("reach_fcs1", 32'(exp_q.size()), 32'd3);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        len_q.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(60, 0, 1'b0, 1'b0, 32'h0);
        wait_idle();
        check("fc_after_reset_frame", {16'b0, frame_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 Parameter IFG_CYCLES, default 12: idle cycles (TX_EN=0) enforced after every frame or abort.
REQ-002 Parameter MIN_FRAME, default 60: minimum bytes from destination MAC up to, but excluding, FCS; used only when padding is compiled in.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 S_DATA  in  8  frame byte from upstream (destination MAC onward, no preamble, no FCS).
REQ-006 S_VALID  in  1  S_DATA valid.
REQ-007 S_LAST  in  1  S_DATA is the final byte of the frame.
REQ-008 S_READY  out  1  framer accepts S_DATA this cycle.
REQ-009 TX_DATA  out  8  registered byte to the MAC/PHY serializer.
REQ-010 TX_EN  out  1  registered; TX_DATA is valid frame content.
REQ-011 BUSY  out  1  high in any state other than IDLE.
REQ-012 UNDERRUN  out  1  sticky; last frame aborted by upstream starvation.
REQ-013 FRAME_CNT  out  16  completed frames, wraps 0xFFFF->0x0000.

Function
REQ-014 States SHALL be IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
REQ-015 A byte transfers when S_VALID=1 and S_READY=1 in the same cycle.
REQ-016 IDLE: S_READY=0; S_VALID=1 at cycle T0 SHALL move to PREAMBLE and clear UNDERRUN.
REQ-017 PREAMBLE: TX_EN=1 in T1..T8; TX_DATA 0x55 for T1..T7, 0xD5 at T8.
REQ-018 S_READY SHALL be 1 during T8 and throughout DATA; a byte accepted in cycle k SHALL appear on TX_DATA in cycle k+1.
REQ-019 DATA: acceptance of S_LAST SHALL leave DATA; S_READY=0 from the next cycle until the frame's IFG ends.
REQ-020 DATA: S_VALID=0 while S_READY=1 SHALL abort: TX_EN=0 next cycle, UNDERRUN=1, go to IFG, FRAME_CNT unchanged.
REQ-021 An 11-bit byte counter SHALL count transmitted data and pad bytes, saturating at 2047; no maximum-length enforcement.
REQ-022 FCS: IEEE 802.3 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) over data and pad bytes, sent as 4 bytes, least-significant byte first, immediately after the last data or pad byte.
REQ-023 FRAME_CNT SHALL increment in the cycle the 4th FCS byte is on TX_DATA.
REQ-024 IFG: TX_EN=0, TX_DATA=0x00 for exactly IFG_CYCLES cycles, then IDLE; back-to-back frames with S_VALID held high SHALL show exactly IFG_CYCLES+1 cycles of TX_EN=0 (IFG plus the IDLE detection cycle).
REQ-025 S_LAST on the first accepted byte is legal (1-byte frame).
REQ-026 TX_DATA SHALL be 0x00 whenever TX_EN=0.

Reset
REQ-027 RST_N=0 SHALL immediately force state IDLE, TX_EN=0, TX_DATA=0x00, S_READY=0, BUSY=0, UNDERRUN=0, FRAME_CNT=0, CRC=0xFFFFFFFF, counters 0, including mid-frame.
REQ-028 Reset release SHALL be used synchronously to CLK; first frame may start on the first rising edge after release.

Configuration
REQ-029 Macro ETH_TX_PAD_EN defined: if byte count < MIN_FRAME at S_LAST, PAD state SHALL send 0x00 bytes until count = MIN_FRAME, pad bytes included in CRC, then FCS.
REQ-030 Macro ETH_TX_PAD_EN undefined: PAD state and its logic SHALL be absent; FCS always follows the last data byte directly.

Verification
REQ-031 60 bytes 0x00..0x3B, S_VALID held -> TX_EN high exactly 72 cycles (8+60+4), FCS equals software CRC-32, FRAME_CNT 0->1.
REQ-032 Pad off: 9 bytes 0x31..0x39 ("123456789") -> FCS bytes 0x26,0x39,0xF4,0xCB; TX_EN high 21 cycles.
REQ-033 Pad on: 14-byte frame -> 46 bytes 0x00 after data, TX_EN high 72 cycles; same stimulus pad off -> 26 cycles.
REQ-034 Two frames back-to-back, S_VALID held -> TX_EN low exactly 13 cycles between them (IFG_CYCLES=12), FRAME_CNT=2.
REQ-035 Drop S_VALID at data byte 20 -> TX_EN=0 next cycle, UNDERRUN=1, FRAME_CNT unchanged; next frame after IFG clears UNDERRUN and completes normally.
REQ-036 RST_N low during 2nd FCS byte -> all outputs at reset values within the same cycle; a following 60-byte frame is bit-exact with REQ-031.
